ram_scan_reader: RTL and testbench
==================================

# ram_scan_reader

Read-port sequencer for the 32×8 switch-written lab RAM: the reading end of the RAM interface whose write port is driven from the switch/DFF path. On each 1 Hz tick, or on a single-step pulse, it issues one RAM read, waits out the RAM read latency, and presents the address/data pair to the 7-segment display path over a valid/ready handshake. It snoops the write port so a read that collides with a concurrent write never displays stale data.

## Interface
- `ADDR_WIDTH`, default 5: RAM address width; the scan wraps at 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 8: RAM word width.
- `RD_LATENCY`, default 1: RAM clock-to-data latency in cycles; legal values are 1 and 2.

Ports:
- `CLOCK_50`, in, 1: the single clock. All logic is on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: one-cycle scan pacing pulse from the 1 Hz divider.
- `run`, in, 1: when high, `tick` starts a read.
- `step`, in, 1: one-cycle pulse that starts one read regardless of `run`.
- `wr_en`, in, 1: snoop of the RAM write enable.
- `wr_addr`, in, ADDR_WIDTH: snoop of the RAM write address.
- `rd_addr`, out, ADDR_WIDTH: RAM read address, registered.
- `rd_data`, in, DATA_WIDTH: RAM read data.
- `out_addr`, out, ADDR_WIDTH: address of the presented word.
- `out_data`, out, DATA_WIDTH: presented word.
- `out_valid`, out, 1: presented pair is valid.
- `out_ready`, in, 1: the display path accepts the pair.
- `wrap`, out, 1: one-cycle pulse when the pair at the last address is accepted.
- `overrun`, out, 1: sticky flag; a start request arrived while the block was busy.

## Operation
- State machine states: IDLE, ISSUE, WAIT, PRESENT.
- A start request is `(tick & run) | step`.
- **IDLE**
  - A start request moves to ISSUE.
  - Otherwise the block stays in IDLE.
- **ISSUE**
  - `rd_addr` equals `cur_addr`.
  - Latency counter loads `RD_LATENCY-1`; next state is WAIT.
- **WAIT**
  - While the counter is non-zero: decrement.
  - When the counter is zero: register `out_data<=rd_data` and `out_addr<=cur_addr`, set `out_valid`, go to PRESENT.
- **PRESENT**
  - `out_valid`, `out_addr` and `out_data` hold stable until `out_ready` is high.
  - On handshake (`out_valid & out_ready`):
    - `cur_addr` increments modulo 2^ADDR_WIDTH, so 31 wraps to 0.
    - `out_valid` clears on the next edge.
    - `wrap` pulses if `cur_addr` was all-ones.
    - Next state is IDLE.
- **Overrun**
  - A start request in any state other than IDLE is dropped.
  - It sets `overrun`, which clears only on `RST`.
  - A start request and a handshake in the same cycle count as an overrun, because the block is still in PRESENT.
- **Reset**
  - Reset values: state IDLE, `cur_addr=0`, `rd_addr=0`, `out_addr=0`, `out_data=0`, `out_valid=0`, `wrap=0`, `overrun=0`.
  - `RST` asserted in any state, including mid-read, aborts the read and forces these values on the next edge.

## Timing
- `rd_addr` changes on the edge entering ISSUE; the RAM samples it at the end of ISSUE.
- Minimum latency from a start request to `out_valid`=1, with no collision:
  - RD_LATENCY=1: 3 edges.
  - RD_LATENCY=2: 4 edges.
- `out_valid` rises on the edge leaving WAIT.
- Minimum request-to-request spacing is latency+1 cycles with `out_ready` tied high; tick spacing is about 50 M cycles.
- `wrap` is high for exactly the one cycle after the accepting edge.

## Configuration
- `SCAN_COLLISION_REREAD_EN` defined:
  - A collision is `wr_en & (wr_addr==cur_addr)` in ISSUE or WAIT.
  - On a collision, the next state is ISSUE: the read reissues and the latency counter reloads.
  - Back-to-back colliding writes stall the read until `wr_en` drops or the address differs.
  - No overrun is flagged for this.
- `SCAN_COLLISION_REREAD_EN` undefined:
  - The write snoop is ignored; `wr_en`/`wr_addr` are unused.
  - Data returned during a colliding write is whatever the RAM returns (read-during-write behaviour of the RAM).

## Test plan
- Reset, then `step` with RAM[0]=0x3C and `out_ready`=1:
  - `out_valid` at edge 3 (RD_LATENCY=1) with `out_addr`=0 and `out_data`=0x3C.
  - Handshake, then `cur_addr`=1 and state IDLE.
- `run`=1 and 32 ticks with RAM[i]=i+0x40:
  - Presented pairs are (0,0x40) through (31,0x5F).
  - `wrap` pulses once after address 31; the 33rd tick reads address 0.
- `out_ready`=0 for 10 cycles while PRESENT:
  - `out_valid`, `out_addr` and `out_data` stay constant.
  - A `tick` in that window sets `overrun`=1, which stays 1 until `RST`.
- With the macro defined, write 0xA5 to `cur_addr` during WAIT:
  - The read reissues.
  - The presented `out_data`=0xA5 arrives one ISSUE+WAIT period later than the no-collision case.
- `RST` pulsed while in WAIT at `cur_addr`=7:
  - All outputs return to reset values on the next edge.
  - The next `step` reads address 0.
- RD_LATENCY=2 build: `step` gives `out_valid` on edge 4 with the correct data.

Source files
------------

// File: rtl/ram_scan_reader_if.sv
// ram_scan_reader_if
// Presentation stream from the RAM scan reader to the 7-segment display path.
//   out_addr  : address of the presented word
//   out_data  : presented RAM word
//   out_valid : pair is valid; stays asserted and stable until accepted
//   out_ready : display path accepts the pair
// master modport: the scan reader (drives the pair). slave modport: the display path.
interface ram_scan_reader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_addr,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_addr,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ram_scan_reader.sv
// ram_scan_reader
// Read-port sequencer for the switch-written lab RAM. Each start request
// ((tick & run) | step) issues one RAM read, waits out the RAM read latency,
// and presents the (address, data) pair on a valid/ready stream. A start
// request that arrives while a read is in flight is dropped and recorded in
// the sticky overrun flag.
//
// Optional feature macro: SCAN_COLLISION_REREAD_EN
//   defined   : a write to cur_addr seen during ISSUE or WAIT reissues the read,
//               so the presented word never predates the write.
//   undefined : wr_en / wr_addr are ignored; colliding reads return whatever
//               the RAM's read-during-write behaviour produces.
//
// Ports:
//   CLOCK_50 : clock, rising edge
//   RST      : synchronous active-high reset
//   tick     : 1 Hz pacing pulse, starts a read when run is high
//   run      : enables tick-paced scanning
//   step     : single-step pulse, starts a read regardless of run
//   wr_en    : RAM write enable snoop
//   wr_addr  : RAM write address snoop
//   rd_addr  : registered RAM read address
//   rd_data  : RAM read data (RD_LATENCY cycles after rd_addr is sampled)
//   out_bus  : presentation stream (ram_scan_reader_if, master side)
//   wrap     : one-cycle pulse after the last address's pair is accepted
//   overrun  : sticky, start request seen while busy; cleared only by RST
//
// RD_LATENCY must be 1 or 2.
module ram_scan_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  step,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  ram_scan_reader_if.master     out_bus,
  output logic                  wrap,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT    = 2'b10,
    PRESENT = 2'b11
  } state_t;

  // Counter preload: WAIT lasts RD_LATENCY cycles so data sampled at the end
  // of ISSUE has settled on rd_data when WAIT is left.
  localparam logic [1:0]            LAT_LOAD  = 2'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [ADDR_WIDTH-1:0] out_addr_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic                  wrap_r;
  logic                  overrun_r;
  logic [1:0]            lat_cnt_r;

  logic                  start_req_s;
  logic                  handshake_s;
  logic                  collision_s;

  assign start_req_s = (tick & run) | step;
  assign handshake_s = out_valid_r & out_bus.out_ready;

`ifdef SCAN_COLLISION_REREAD_EN
  // Only meaningful in ISSUE/WAIT; the FSM ignores it elsewhere.
  assign collision_s = wr_en & (wr_addr == cur_addr_r);
`else
  assign collision_s = 1'b0;
  // Write snoop is not used in this build.
  logic unused_snoop_s;
  assign unused_snoop_s = &{1'b0, wr_en, wr_addr};
`endif

  // Scan FSM with all outputs registered.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_r     <= IDLE;
      cur_addr_r  <= {ADDR_WIDTH{1'b0}};
      rd_addr_r   <= {ADDR_WIDTH{1'b0}};
      out_addr_r  <= {ADDR_WIDTH{1'b0}};
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      wrap_r      <= 1'b0;
      overrun_r   <= 1'b0;
      lat_cnt_r   <= 2'd0;
    end else begin
      wrap_r <= 1'b0;

      // Requests outside IDLE are dropped, including one coinciding with
      // the accepting handshake (the block is still in PRESENT then).
      if (start_req_s && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      case (state_r)
        IDLE: begin
          if (start_req_s) begin
            rd_addr_r <= cur_addr_r;
            state_r   <= ISSUE;
          end else begin
            state_r   <= IDLE;
          end
        end

        ISSUE: begin
          rd_addr_r <= cur_addr_r;
          lat_cnt_r <= LAT_LOAD;
          // A write landing this cycle races the RAM sample; issue again.
          if (collision_s) begin
            state_r <= ISSUE;
          end else begin
            state_r <= WAIT;
          end
        end

        WAIT: begin
          if (collision_s) begin
            state_r <= ISSUE;
          end else if (lat_cnt_r != 2'd0) begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
            state_r   <= WAIT;
          end else begin
            out_data_r  <= rd_data;
            out_addr_r  <= cur_addr_r;
            out_valid_r <= 1'b1;
            state_r     <= PRESENT;
          end
        end

        PRESENT: begin
          if (handshake_s) begin
            cur_addr_r  <= cur_addr_r + ADDR_ONE;
            out_valid_r <= 1'b0;
            wrap_r      <= (cur_addr_r == ADDR_LAST);
            state_r     <= IDLE;
          end else begin
            state_r     <= PRESENT;
          end
        end

        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr           = rd_addr_r;
  assign out_bus.out_addr  = out_addr_r;
  assign out_bus.out_data  = out_data_r;
  assign out_bus.out_valid = out_valid_r;
  assign wrap              = wrap_r;
  assign overrun           = overrun_r;

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader
// Drives ram_scan_reader (RD_LATENCY=1) and a second instance with
// RD_LATENCY=2 against a behavioural synchronous RAM. Expected pairs come
// from a scan model: a model address that advances by one (mod 32) per
// accepted pair, and a model copy of every word written into the RAM.
module tb_ram_scan_reader;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;

  logic          CLOCK_50 = 1'b0;
  logic          RST = 1'b0;
  logic          tick = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wrap;
  logic          overrun;

  logic          step2 = 1'b0;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data2;
  logic          wrap2;
  logic          overrun2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr = 0;
  logic [DW-1:0] exp_mem [DEPTH];

  always #5 CLOCK_50 = ~CLOCK_50;

  ram_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ram_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  ram_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .tick(tick), .run(run), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_bus(bus), .wrap(wrap), .overrun(overrun)
  );

  ram_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut2 (
    .CLOCK_50(CLOCK_50), .RST(RST), .tick(1'b0), .run(1'b0), .step(step2),
    .wr_en(1'b0), .wr_addr({AW{1'b0}}), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .out_bus(bus2), .wrap(wrap2), .overrun(overrun2)
  );

  // Lab RAM: one write port, two read ports (1-cycle and 2-cycle latency),
  // read-during-write returns the old word.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] q1, q2a, q2b;
  always @(posedge CLOCK_50) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    q1  <= ram[rd_addr];
    q2a <= ram[rd_addr2];
    q2b <= q2a;
  end
  assign rd_data  = q1;
  assign rd_data2 = q2b;

  task automatic clk_edge();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ram_write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    clk_edge();
    wr_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    clk_edge();
    RST = 1'b0;
    exp_addr = 0;
  endtask

  // One complete read: start, wait for the pair, optional back-pressure, accept.
  task automatic do_read(input bit use_tick, input int hold);
    int  waited;
    bit  stable;
    logic exp_wrap;
    bus.out_ready = (hold == 0);
    if (use_tick) begin run = 1'b1; tick = 1'b1; end
    else step = 1'b1;
    clk_edge();
    tick = 1'b0; step = 1'b0;
    n_tests++;
    if (rd_addr !== AW'(exp_addr)) begin
      n_fail++; $display("FAIL read_rd_addr got %0d want %0d", rd_addr, exp_addr);
    end
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin clk_edge(); waited++; end
    n_tests++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL read_valid_timeout got %b want 1", bus.out_valid);
    end
    n_tests++;
    if (bus.out_addr !== AW'(exp_addr) || bus.out_data !== exp_mem[exp_addr]) begin
      n_fail++;
      $display("FAIL read_pair got (%0d,%h) want (%0d,%h)", bus.out_addr, bus.out_data,
               exp_addr, exp_mem[exp_addr]);
    end
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      clk_edge();
      if (bus.out_valid !== 1'b1 || bus.out_addr !== AW'(exp_addr) ||
          bus.out_data !== exp_mem[exp_addr]) stable = 1'b0;
    end
    if (hold > 0) begin
      n_tests++;
      if (!stable) begin n_fail++; $display("FAIL read_hold_stable got 0 want 1"); end
    end
    bus.out_ready = 1'b1;
    clk_edge();
    exp_wrap = (exp_addr == DEPTH - 1);
    n_tests++;
    if (bus.out_valid !== 1'b0 || wrap !== exp_wrap) begin
      n_fail++; $display("FAIL read_accept got valid=%b wrap=%b want valid=0 wrap=%b",
                         bus.out_valid, wrap, exp_wrap);
    end
    exp_addr = (exp_addr + 1) % DEPTH;
    clk_edge();
    n_tests++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle got %b want 0", wrap); end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clk_edge(); clk_edge();
    RST = 1'b0;
    exp_addr = 0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== '0 || bus.out_data !== '0 ||
        rd_addr !== '0 || wrap !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got v=%b a=%0d d=%h ra=%0d w=%b o=%b want all 0",
               bus.out_valid, bus.out_addr, bus.out_data, rd_addr, wrap, overrun);
    end
    n_tests++;
    if (bus2.out_valid !== 1'b0 || rd_addr2 !== '0 || overrun2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_values_lat2 got v=%b ra=%0d o=%b want 0",
                         bus2.out_valid, rd_addr2, overrun2);
    end
  endtask

  task automatic test_step_latency();
    for (int i = 0; i < DEPTH; i++) ram_write(i, 8'($urandom));
    ram_write(0, 8'h3C);
    bus.out_ready = 1'b1;
    step = 1'b1;
    clk_edge();                     // edge 1
    step = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL step_edge1 got %b want 0", bus.out_valid); end
    clk_edge();                     // edge 2
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL step_edge2 got %b want 0", bus.out_valid); end
    clk_edge();                     // edge 3
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd0 || bus.out_data !== 8'h3C) begin
      n_fail++; $display("FAIL step_edge3 got v=%b a=%0d d=%h want v=1 a=0 d=3c",
                         bus.out_valid, bus.out_addr, bus.out_data);
    end
    clk_edge();                     // edge 4: accepted
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL step_accept got %b want 0", bus.out_valid); end
    exp_addr = 1;
    do_read(1'b0, 0);               // next step must read address 1
  endtask

  task automatic test_scan();
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) ram_write(i, 8'(i + 8'h40));
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_read(1'b1, 0);
      repeat ($urandom_range(0, 3)) clk_edge();
    end
    for (int i = 0; i < DEPTH; i++) ram_write(i, 8'($urandom));
    for (int i = 0; i < DEPTH; i++) do_read(1'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_run_gate();
    logic [AW-1:0] last_rd;
    last_rd = AW'((exp_addr + DEPTH - 1) % DEPTH);
    run = 1'b0; tick = 1'b1;
    clk_edge();
    tick = 1'b0;
    repeat (4) clk_edge();
    n_tests++;
    if (bus.out_valid !== 1'b0 || rd_addr !== last_rd || overrun !== 1'b0) begin
      n_fail++; $display("FAIL run_gate got v=%b ra=%0d o=%b want v=0 ra=%0d o=0",
                         bus.out_valid, rd_addr, overrun, last_rd);
    end
  endtask

  task automatic test_overrun();
    int waited;
    bit stable;
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_initial got %b want 0", overrun); end
    bus.out_ready = 1'b0;
    step = 1'b1;
    clk_edge();
    step = 1'b0;
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin clk_edge(); waited++; end
    stable = (bus.out_valid === 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin run = 1'b1; tick = 1'b1; end
      clk_edge();
      tick = 1'b0;
      if (bus.out_valid !== 1'b1 || bus.out_addr !== AW'(exp_addr) ||
          bus.out_data !== exp_mem[exp_addr]) stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin n_fail++; $display("FAIL backpressure_stable got 0 want 1"); end
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b want 1", overrun); end
    bus.out_ready = 1'b1;
    clk_edge();
    exp_addr = (exp_addr + 1) % DEPTH;
    clk_edge();
    do_read(1'b0, 0);
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    int waited;
    pulse_reset();
    bus.out_ready = 1'b0;
    step = 1'b1;
    clk_edge();
    step = 1'b0;
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin clk_edge(); waited++; end
    // request arrives on the accepting edge: dropped as an overrun
    bus.out_ready = 1'b1; step = 1'b1;
    clk_edge();
    step = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL handshake_and_start got v=%b o=%b want v=0 o=1", bus.out_valid, overrun);
    end
    exp_addr = 1;
    clk_edge();
    n_tests++;
    if (bus.out_valid !== 1'b0 || rd_addr !== 5'd0) begin
      n_fail++; $display("FAIL dropped_request got v=%b ra=%0d want v=0 ra=0", bus.out_valid, rd_addr);
    end
    do_read(1'b0, 0);
  endtask

  task automatic test_collision();
    logic [DW-1:0] old_d;
    logic [DW-1:0] exp_d;
    int exp_edges;
    int edges;
    old_d = 8'($urandom);
    if (old_d == 8'hA5) old_d = 8'h5A;
    ram_write(exp_addr, old_d);
`ifdef SCAN_COLLISION_REREAD_EN
    exp_d = 8'hA5; exp_edges = 5;
`else
    exp_d = old_d; exp_edges = 3;
`endif
    bus.out_ready = 1'b1;
    step = 1'b1;
    clk_edge();                     // edge 1: ISSUE
    step = 1'b0;
    clk_edge();                     // edge 2: WAIT
    wr_en = 1'b1; wr_addr = AW'(exp_addr); wr_data = 8'hA5;
    clk_edge();                     // edge 3
    wr_en = 1'b0;
    exp_mem[exp_addr] = 8'hA5;
    edges = 3;
    while (bus.out_valid !== 1'b1 && edges < 20) begin clk_edge(); edges++; end
    n_tests++;
    if (edges != exp_edges || bus.out_data !== exp_d || bus.out_addr !== AW'(exp_addr)) begin
      n_fail++; $display("FAIL collision got edge=%0d d=%h a=%0d want edge=%0d d=%h a=%0d",
                         edges, bus.out_data, bus.out_addr, exp_edges, exp_d, exp_addr);
    end
    clk_edge();
    exp_addr = (exp_addr + 1) % DEPTH;
    clk_edge();
    do_read(1'b0, 0);               // RAM now holds A5 at the collided address
  endtask

  task automatic test_reset_midread();
    while (exp_addr != 7) do_read(1'b0, 0);
    bus.out_ready = 1'b1;
    step = 1'b1;
    clk_edge();                     // ISSUE
    step = 1'b0;
    clk_edge();                     // WAIT
    RST = 1'b1;
    clk_edge();
    RST = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== '0 || bus.out_data !== '0 ||
        rd_addr !== '0 || wrap !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL midread_reset got v=%b a=%0d d=%h ra=%0d w=%b o=%b want all 0",
               bus.out_valid, bus.out_addr, bus.out_data, rd_addr, wrap, overrun);
    end
    exp_addr = 0;
    clk_edge();
    do_read(1'b0, 0);
  endtask

  task automatic test_latency2();
    bus2.out_ready = 1'b1;
    step2 = 1'b1;
    clk_edge();                     // edge 1
    step2 = 1'b0;
    clk_edge(); clk_edge();         // edges 2, 3
    n_tests++;
    if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat2_edge3 got %b want 0", bus2.out_valid); end
    clk_edge();                     // edge 4
    n_tests++;
    if (bus2.out_valid !== 1'b1 || bus2.out_addr !== 5'd0 || bus2.out_data !== exp_mem[0]) begin
      n_fail++; $display("FAIL lat2_edge4 got v=%b a=%0d d=%h want v=1 a=0 d=%h",
                         bus2.out_valid, bus2.out_addr, bus2.out_data, exp_mem[0]);
    end
    clk_edge();
    n_tests++;
    if (bus2.out_valid !== 1'b0 || overrun2 !== 1'b0) begin
      n_fail++; $display("FAIL lat2_accept got v=%b o=%b want 0 0", bus2.out_valid, overrun2);
    end
  endtask

  initial begin
    bus.out_ready  = 1'b0;
    bus2.out_ready = 1'b0;
    test_reset();
    test_step_latency();
    test_scan();
    test_run_gate();
    test_overrun();
    test_back_to_back();
    test_collision();
    test_reset_midread();
    test_latency2();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
